// File: rtl/tc_program_multi.sv
// Multi-port byte-addressed program memory with registered little-endian word fetch
// and a valid/ready streaming loader for run-time writes.

module tc_fetch_lane #(
    parameter int ADDR_WIDTH = 16,
    parameter int MEM_BYTES  = 65536,
    parameter int WORD_BYTES = 1
) (
    input  logic [ADDR_WIDTH-1:0]                  addr,
    output logic [WORD_BYTES-1:0][ADDR_WIDTH-1:0]  idx,
    output logic [WORD_BYTES-1:0]                  hit
);
    localparam logic [ADDR_WIDTH:0] MEMSZ = (ADDR_WIDTH+1)'(MEM_BYTES);

    // A base inside storage wraps modulo MEM_BYTES; a base outside storage reads zero.
    for (genvar i = 0; i < WORD_BYTES; i++) begin : g_byte
        logic [ADDR_WIDTH:0] sum;
        assign sum    = {1'b0, addr} + (ADDR_WIDTH+1)'(i);
        assign idx[i] = (sum >= MEMSZ) ? ADDR_WIDTH'(sum - MEMSZ) : sum[ADDR_WIDTH-1:0];
        assign hit[i] = ({1'b0, addr} < MEMSZ);
    end
endmodule

module tc_program_multi #(
    parameter int ADDR_WIDTH = 16,
    parameter int MEM_BYTES  = 65536,
    parameter int WORD_BYTES = 1,
    parameter int PORTS      = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [PORTS*ADDR_WIDTH-1:0]     address,
    output logic [PORTS*WORD_BYTES*8-1:0]   out,
    input  logic                            load_start,
    input  logic [ADDR_WIDTH-1:0]           load_base,
    input  logic [ADDR_WIDTH:0]             load_len,
    input  logic                            load_valid,
    input  logic [7:0]                      load_data,
    output logic                            load_ready,
    output logic                            load_busy,
    output logic                            load_done
);
    localparam logic [ADDR_WIDTH:0] MEMSZ = (ADDR_WIDTH+1)'(MEM_BYTES);
    localparam logic [ADDR_WIDTH:0] LAST  = MEMSZ - (ADDR_WIDTH+1)'(1);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] ptr;
        logic [ADDR_WIDTH:0]   rem;
    } ld_ctx_t;

    logic [7:0] mem [MEM_BYTES];

    logic [PORTS-1:0][ADDR_WIDTH-1:0]     addr_v;
    logic [PORTS-1:0][WORD_BYTES*8-1:0]   rd_q;
    state_t  state, state_n;
    ld_ctx_t ctx, ctx_n;
    logic    wr_en;

    assign addr_v = address;
    assign out    = rd_q;

    // Read ports sample the pre-write contents, so a same-edge write shows up next fetch.
    for (genvar p = 0; p < PORTS; p++) begin : g_port
        logic [WORD_BYTES-1:0][ADDR_WIDTH-1:0] idx;
        logic [WORD_BYTES-1:0]                 hit;
        logic [WORD_BYTES*8-1:0]               q;

        tc_fetch_lane #(
            .ADDR_WIDTH(ADDR_WIDTH),
            .MEM_BYTES (MEM_BYTES),
            .WORD_BYTES(WORD_BYTES)
        ) u_lane (
            .addr(addr_v[p]),
            .idx (idx),
            .hit (hit)
        );

        always_ff @(posedge clk) begin
            if (rst) q <= '0;
            else
                for (int i = 0; i < WORD_BYTES; i++)
                    q[i*8 +: 8] <= hit[i] ? mem[idx[i]] : 8'h00;
        end

        assign rd_q[p] = q;
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) mem[ctx.ptr] <= load_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ctx   <= '0;
        end else begin
            state <= state_n;
            ctx   <= ctx_n;
        end
    end

    always_comb begin
        state_n    = state;
        ctx_n      = ctx;
        load_ready = 1'b0;
        load_busy  = 1'b0;
        load_done  = 1'b0;
        wr_en      = 1'b0;
        case (state)
            IDLE: begin
                if (load_start) begin
                    ctx_n.ptr = load_base;
                    ctx_n.rem = load_len;
                    state_n   = (load_len != '0) ? LOAD : DONE;
                end
            end
            LOAD: begin
                load_ready = 1'b1;
                load_busy  = 1'b1;
                if (load_valid) begin
                    // Out-of-storage bytes are consumed and counted but never written.
                    wr_en     = ({1'b0, ctx.ptr} < MEMSZ);
                    ctx_n.ptr = ({1'b0, ctx.ptr} == LAST) ? '0 : ctx.ptr + ADDR_WIDTH'(1);
                    ctx_n.rem = ctx.rem - (ADDR_WIDTH+1)'(1);
                    if (ctx.rem == (ADDR_WIDTH+1)'(1)) state_n = DONE;
                end
            end
            DONE: begin
                load_done = 1'b1;
                load_busy = 1'b1;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_tc_program_multi.sv
// Scoreboard bench for tc_program_multi: directed stimulus queues expectations,
// a negedge monitor pops and compares them on their due cycle.

module tb_tc_program_multi;
    localparam int AW = 16;
    localparam int MB = 40000;
    localparam int WB = 4;
    localparam int NP = 2;

    localparam int K_OUT  = 0;
    localparam int K_RDY  = 1;
    localparam int K_BUSY = 2;
    localparam int K_DONE = 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NP*AW-1:0]      address;
    logic [NP*WB*8-1:0]    out;
    logic                  load_start;
    logic [AW-1:0]         load_base;
    logic [AW:0]           load_len;
    logic                  load_valid;
    logic [7:0]            load_data;
    logic                  load_ready;
    logic                  load_busy;
    logic                  load_done;

    tc_program_multi #(
        .ADDR_WIDTH(AW),
        .MEM_BYTES (MB),
        .WORD_BYTES(WB),
        .PORTS     (NP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .address   (address),
        .out       (out),
        .load_start(load_start),
        .load_base (load_base),
        .load_len  (load_len),
        .load_valid(load_valid),
        .load_data (load_data),
        .load_ready(load_ready),
        .load_busy (load_busy),
        .load_done (load_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        int          kind;
        int          port;
        logic [31:0] val;
        logic [31:0] mask;
        string       name;
    } exp_t;

    typedef logic [7:0] bq_t[$];

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic expect_at(input int dly, input int kind, input int port,
                             input logic [31:0] val, input logic [31:0] mask, input string name);
        exp_t e;
        e.due = cyc + dly; e.kind = kind; e.port = port;
        e.val = val; e.mask = mask; e.name = name;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] probe(input int kind, input int port);
        case (kind)
            K_OUT:   return out[port*32 +: 32];
            K_RDY:   return {31'b0, load_ready};
            K_BUSY:  return {31'b0, load_busy};
            default: return {31'b0, load_done};
        endcase
    endfunction

    always @(negedge clk) begin
        logic [31:0] act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
                act = probe(sb[i].kind, sb[i].port);
                vectors++;
                if (sb[i].due < cyc) begin
                    miscompares++;
                    $display("FAIL %s: missed due cycle %0d (now %0d)", sb[i].name, sb[i].due, cyc);
                end else if ((act & sb[i].mask) !== (sb[i].val & sb[i].mask)) begin
                    miscompares++;
                    $display("FAIL %s: got %h want %h (mask %h) at cycle %0d",
                             sb[i].name, act, sb[i].val, sb[i].mask, cyc);
                end
                sb.delete(i);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [AW-1:0] base, input bq_t d);
        load_start = 1'b1;
        load_base  = base;
        load_len   = 17'(d.size());
        tick();
        load_start = 1'b0;
        foreach (d[i]) begin
            load_valid = 1'b1;
            load_data  = d[i];
            if (i == d.size() - 1) expect_at(1, K_DONE, 0, 32'd1, 32'h1, "load_done");
            tick();
        end
        load_valid = 1'b0;
        tick();
    endtask

    task automatic fetch(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [31:0] e0, input logic [31:0] m0,
                         input logic [31:0] e1, input logic [31:0] m1, input string nm);
        address = {a1, a0};
        expect_at(1, K_OUT, 0, e0, m0, {nm, "_p0"});
        expect_at(1, K_OUT, 1, e1, m1, {nm, "_p1"});
        tick();
    endtask

    initial begin
        bq_t bq;
        rst = 1'b1; address = '0; load_start = 1'b0; load_base = '0;
        load_len = '0; load_valid = 1'b0; load_data = '0;

        // Reset state on the second reset edge
        tick();
        expect_at(1, K_OUT,  0, 32'h0, 32'hFFFFFFFF, "rst_out_p0");
        expect_at(1, K_OUT,  1, 32'h0, 32'hFFFFFFFF, "rst_out_p1");
        expect_at(1, K_RDY,  0, 32'h0, 32'h1, "rst_ready");
        expect_at(1, K_BUSY, 0, 32'h0, 32'h1, "rst_busy");
        expect_at(1, K_DONE, 0, 32'h0, 32'h1, "rst_done");
        tick();
        rst = 1'b0;

        // Preload 11 22 33 44 at 0, aligned and unaligned fetch
        bq = '{8'h11, 8'h22, 8'h33, 8'h44};
        load(16'h0000, bq);
        fetch(16'h0000, 16'h0001, 32'h44332211, 32'hFFFFFFFF, 32'h00443322, 32'h00FFFFFF, "pre");

        // Old contents at 0x0100
        bq = '{8'h55, 8'h66, 8'h77, 8'h88};
        load(16'h0100, bq);

        // Stalled load with read-during-write
        load_start = 1'b1; load_base = 16'h0100; load_len = 17'd3;
        for (int k = 1; k <= 5; k++) begin
            expect_at(k, K_RDY,  0, 32'd1, 32'h1, "stall_ready_hi");
            expect_at(k, K_DONE, 0, 32'd0, 32'h1, "stall_done_lo");
        end
        expect_at(6, K_RDY,  0, 32'd0, 32'h1, "stall_ready_off");
        expect_at(6, K_DONE, 0, 32'd1, 32'h1, "stall_done_pulse");
        expect_at(6, K_BUSY, 0, 32'd1, 32'h1, "stall_busy_done");
        expect_at(7, K_DONE, 0, 32'd0, 32'h1, "stall_done_end");
        expect_at(7, K_BUSY, 0, 32'd0, 32'h1, "stall_busy_idle");
        tick();
        load_start = 1'b0;
        load_valid = 1'b1; load_data = 8'hA1; address[15:0] = 16'h0100;
        expect_at(1, K_OUT, 0, 32'h88776655, 32'hFFFFFFFF, "rdw_old");
        tick();
        load_data = 8'hB2;
        expect_at(1, K_OUT, 0, 32'h887766A1, 32'hFFFFFFFF, "rdw_new");
        tick();
        load_valid = 1'b0; load_data = 8'h5A;
        tick(2);
        load_valid = 1'b1; load_data = 8'hC3;
        tick();
        load_data = 8'hFF;
        tick();
        load_valid = 1'b0;
        fetch(16'h0100, 16'h0002, 32'h88C3B2A1, 32'hFFFFFFFF, 32'h00004433, 32'h0000FFFF, "after_stall");

        // Zero length; load_start held into DONE must be ignored
        load_start = 1'b1; load_base = 16'h0300; load_len = 17'd0;
        expect_at(1, K_DONE, 0, 32'd1, 32'h1, "zero_done");
        expect_at(1, K_BUSY, 0, 32'd1, 32'h1, "zero_busy");
        expect_at(1, K_RDY,  0, 32'd0, 32'h1, "zero_ready");
        expect_at(2, K_DONE, 0, 32'd0, 32'h1, "zero_done_end");
        expect_at(2, K_BUSY, 0, 32'd0, 32'h1, "zero_start_ignored");
        tick();
        load_len = 17'd5;
        tick();
        load_start = 1'b0;
        tick();

        // Load across the end of storage, then wrapped and out-of-range fetches
        bq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        load(16'd39998, bq);
        fetch(16'd39999, 16'd39998, 32'h33DDCCBB, 32'hFFFFFFFF, 32'hDDCCBBAA, 32'hFFFFFFFF, "wrap");
        fetch(16'd50000, 16'd39997, 32'h00000000, 32'hFFFFFFFF, 32'hCCBBAA00, 32'hFFFFFF00, "oor");

        // Writes beyond storage are dropped; the 16-bit pointer rolls over to 0
        bq = '{8'hE1, 8'hE2, 8'hE3};
        load(16'hFFFE, bq);
        fetch(16'h0000, 16'hFFFF, 32'h4433DDE3, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, "drop");

        // Reset in the middle of a load
        bq = '{8'h01, 8'h02, 8'h03, 8'h04};
        load(16'h0200, bq);
        load_start = 1'b1; load_base = 16'h0200; load_len = 17'd4;
        tick();
        load_start = 1'b0;
        load_valid = 1'b1; load_data = 8'hF1;
        tick();
        load_data = 8'hF2;
        tick();
        load_data = 8'hF3; rst = 1'b1;
        expect_at(1, K_BUSY, 0, 32'd0, 32'h1, "abort_busy");
        expect_at(1, K_RDY,  0, 32'd0, 32'h1, "abort_ready");
        expect_at(1, K_DONE, 0, 32'd0, 32'h1, "abort_done");
        expect_at(1, K_OUT,  0, 32'h0, 32'hFFFFFFFF, "abort_out");
        expect_at(2, K_DONE, 0, 32'd0, 32'h1, "abort_no_done");
        tick();
        rst = 1'b0; load_valid = 1'b0;
        fetch(16'h0200, 16'h0100, 32'h0403F2F1, 32'hFFFFFFFF, 32'h88C3B2A1, 32'hFFFFFFFF, "abort_kept");

        tick(3);
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
            miscompares += sb.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
